twiddle_sequencer: RTL and testbench
====================================

// Module: twiddle_sequencer
// PURPOSE
//  Produces the W twiddle-factor stream for the complex multiplier's W operand, one word per butterfly of a radix-2 DIT stage.
//  On start it emits POINTS/2 twiddles over a valid/ready handshake, then returns to idle.
//  Values come from an internal quarter-wave magnitude ROM and use the datapath's sign-magnitude fixed-point format.
//  The inverse flag conjugates every word for IFFT passes.
// PARAMETERS
//  N       8   word width per component; bit N-1 = sign, bits N-2:0 = magnitude
//  Q       6   fractional bits; 1.0 = 2**Q
//  POINTS  8   transform length; legal values 4, 8, 16, 32
//  LOGP    3   log2(POINTS); must match POINTS
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        synchronous, active-high reset
//  start     in   1        request one stage's twiddle stream; sampled only in IDLE
//  stage     in   LOGP     DIT stage index s, 0..LOGP-1
//  inverse   in   1        1 = conjugate output (IFFT)
//  busy      out  1        high in RUN
//  tw_valid  out  1        tw_out holds a valid twiddle
//  tw_ready  in   1        consumer accepts tw_out this cycle
//  tw_out    out  2N       {real[N-1:0], imag[N-1:0]}
//  tw_last   out  1        qualifies the final word of the stream
//  err       out  1        one-cycle pulse: start with stage >= LOGP
// BEHAVIOUR
//  Reset: state=IDLE; busy, tw_valid, tw_last and err = 0; tw_out = 0; j = 0.
//  Reset mid-stream aborts immediately. Nothing resumes after reset.
//  FSM IDLE:
//   - start && stage<LOGP: latch stage and inverse; load word j=0; go to RUN.
//   - start && stage>=LOGP: pulse err for one cycle; stay in IDLE.
//  FSM RUN:
//   - tw_valid=1 and tw_out/tw_last are stable while !tw_ready.
//   - On tw_valid&&tw_ready with j<POINTS/2-1: load j+1 for the next cycle (no bubble).
//   - On the handshake with j=POINTS/2-1 (tw_last=1): go to IDLE; tw_valid=0 next cycle.
//   - start is ignored in RUN, including the cycle of the last handshake.
//  Latency: start at edge t gives tw_valid=1 after edge t; throughput is 1 word/cycle with tw_ready held high.
//  Index: k = (j mod 2**s) << (LOGP-1-s), for j = 0..POINTS/2-1.
//  W^k = cos(2*pi*k/P) - j*sin(2*pi*k/P).
//  ROM: C[m] = round(2**Q * cos(2*pi*m/32)), m = 0..8 = 64,63,59,53,45,36,24,12,0.
//   - Access C[m*(32/POINTS)].
//  Real part:
//   - k < P/4: +C[k].
//   - k = P/4: 0.
//   - k > P/4: -C[P/2-k].
//  Imag part: -C[P/4-k] for k <= P/4; -C[k-P/4] for k > P/4.
//  Zero: any zero magnitude is encoded +0 (sign bit 0); a negative zero is never emitted.
//  inverse=1: flip the imag sign bit when the imag magnitude is nonzero. Real is unchanged.
//  tw_out is registered; all outputs come directly from flops.
// TESTING
//  T1 P=8, stage=2, inverse=0, ready=1 -> words 4000,2DAD,00C0,ADAD on 4 consecutive cycles; tw_last on 4th; busy falls after.
//  T2 P=8, stage=1 -> 4000,00C0,4000,00C0.  stage=0 -> 4000 four times.
//  T3 P=8, stage=2, inverse=1 -> 4000,2D2D,0040,AD2D; no 8000 or 0080 negative zero appears.
//  T4 tw_ready toggled 1,0,0,1,0,1,1 -> each word held stable while stalled; exactly 4 handshakes; no word lost or duplicated.
//  T5 start pulsed every cycle during RUN and at the last handshake -> ignored; a start issued later in IDLE begins a fresh stream.
//  T6 stage=3 with P=8 -> err=1 for 1 cycle; busy=0.  rst asserted after word 2 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/twiddle_sequencer.sv
// Twiddle-factor stream generator for one radix-2 DIT stage: emits POINTS/2
// sign-magnitude W words over valid/ready, optionally conjugated for IFFT.
module twiddle_sequencer #(
    parameter int N      = 8,
    parameter int Q      = 6,
    parameter int POINTS = 8,
    parameter int LOGP   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LOGP-1:0] stage,
    input  logic            inverse,
    output logic            busy,
    output logic            tw_valid,
    input  logic            tw_ready,
    output logic [2*N-1:0]  tw_out,
    output logic            tw_last,
    output logic            err
);
    localparam int HALF = POINTS / 2;
    localparam int JW   = (LOGP > 1) ? LOGP - 1 : 1;
    localparam int SC   = 32 / POINTS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [JW-1:0]   j, j_n;
    logic [LOGP-1:0] stage_q, stage_n;
    logic            inv_q, inv_n;
    logic            busy_n, valid_n, last_n, err_n;
    logic [2*N-1:0]  out_n;

    // Quarter-wave cosine held at 14 fractional bits, reduced to Q bits on read.
    function automatic int rom_q14(input int m);
        case (m)
            0:       return 16384;
            1:       return 16069;
            2:       return 15137;
            3:       return 13623;
            4:       return 11585;
            5:       return 9102;
            6:       return 6270;
            7:       return 3196;
            default: return 0;
        endcase
    endfunction

    function automatic logic [N-2:0] round_q(input int v);
        int r;
        r = (v + (1 << (13 - Q))) >>> (14 - Q);
        return (N-1)'(r);
    endfunction

    // Sign-magnitude packing; a zero magnitude never carries the sign bit.
    function automatic logic [N-1:0] sm_encode(input logic neg, input logic [N-2:0] mag);
        return {neg && (mag != '0), mag};
    endfunction

    function automatic logic [2*N-1:0] twiddle(input logic [JW-1:0] jj,
                                               input logic [LOGP-1:0] s,
                                               input logic inv);
        int k, mr, mi;
        logic rneg;
        logic [N-2:0] rmag, imag_mag;
        k = (int'(jj) % (1 << s)) << (LOGP - 1 - int'(s));
        if (k < POINTS / 4) begin
            rneg = 1'b0;
            mr   = k * SC;
        end else if (k == POINTS / 4) begin
            rneg = 1'b0;
            mr   = 8;
        end else begin
            rneg = 1'b1;
            mr   = (POINTS / 2 - k) * SC;
        end
        if (k <= POINTS / 4) mi = (POINTS / 4 - k) * SC;
        else                 mi = (k - POINTS / 4) * SC;
        rmag     = round_q(rom_q14(mr));
        imag_mag = round_q(rom_q14(mi));
        // Imag is -sin: negative unless conjugated for the inverse transform.
        return {sm_encode(rneg, rmag), sm_encode(!inv, imag_mag)};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            j        <= '0;
            stage_q  <= '0;
            inv_q    <= 1'b0;
            busy     <= 1'b0;
            tw_valid <= 1'b0;
            tw_last  <= 1'b0;
            err      <= 1'b0;
            tw_out   <= '0;
        end else begin
            state    <= state_n;
            j        <= j_n;
            stage_q  <= stage_n;
            inv_q    <= inv_n;
            busy     <= busy_n;
            tw_valid <= valid_n;
            tw_last  <= last_n;
            err      <= err_n;
            tw_out   <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        j_n     = j;
        stage_n = stage_q;
        inv_n   = inv_q;
        valid_n = tw_valid;
        last_n  = tw_last;
        out_n   = tw_out;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (int'(stage) < LOGP) begin
                        state_n = RUN;
                        stage_n = stage;
                        inv_n   = inverse;
                        j_n     = '0;
                        valid_n = 1'b1;
                        out_n   = twiddle('0, stage, inverse);
                        last_n  = (HALF == 1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tw_valid && tw_ready) begin
                    if (j == JW'(HALF - 1)) begin
                        state_n = IDLE;
                        j_n     = '0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                    end else begin
                        j_n    = j + 1'b1;
                        out_n  = twiddle(j + 1'b1, stage_q, inv_q);
                        last_n = (j + 1'b1 == JW'(HALF - 1));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN);
    end
endmodule

// File: tb/tb_twiddle_sequencer.sv
// Scoreboard bench for twiddle_sequencer (P=8): stimulus queues expected words,
// a negedge monitor pops them on every handshake and checks stall stability.
module tb_twiddle_sequencer;
    logic        clk = 0;
    logic        rst, start, inverse, tw_ready;
    logic [2:0]  stage;
    logic        busy, tw_valid, tw_last, err;
    logic [15:0] tw_out;

    int checks = 0;
    int errors = 0;
    int hs = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_w;
    logic [16:0] held;
    logic        held_v = 0;
    logic        pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    twiddle_sequencer #(.N(8), .Q(6), .POINTS(8), .LOGP(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage), .inverse(inverse),
        .busy(busy), .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_out(tw_out),
        .tw_last(tw_last), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            held_v = 0;
        end else if (tw_valid) begin
            if (held_v) begin
                checks++;
                if ({tw_last, tw_out} !== held) begin
                    errors++;
                    $display("FAIL stall_hold got %h want %h", {tw_last, tw_out}, held);
                end
            end
            if (tw_ready) begin
                hs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h want none", {tw_last, tw_out});
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({tw_last, tw_out} !== exp_w) begin
                        errors++;
                        $display("FAIL stream_word got last=%b w=%h want last=%b w=%h",
                                 tw_last, tw_out, exp_w[16], exp_w[15:0]);
                    end
                end
                held_v = 0;
            end else begin
                held_v = 1;
                held   = {tw_last, tw_out};
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic push4(input logic [15:0] w0, w1, w2, w3);
        exp_q.push_back({1'b0, w0});
        exp_q.push_back({1'b0, w1});
        exp_q.push_back({1'b0, w2});
        exp_q.push_back({1'b1, w3});
    endtask

    task automatic start_stream(input logic [2:0] s, input logic inv);
        @(posedge clk); #1;
        start = 1; stage = s; inverse = inv;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
        chk({nm, "_valid_low"}, {31'd0, tw_valid}, 32'd0);
    endtask

    initial begin
        int h0;
        rst = 1; start = 0; stage = 0; inverse = 0; tw_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_valid", {31'd0, tw_valid}, 0);
        chk("reset_last", {31'd0, tw_last}, 0);
        chk("reset_err", {31'd0, err}, 0);
        chk("reset_out", {16'd0, tw_out}, 0);
        rst = 0;

        // T1: stage 2 forward, full rate
        push4(16'h4000, 16'h2DAD, 16'h00C0, 16'hADAD);
        start_stream(3'd2, 1'b0);
        chk("t1_latency_valid", {31'd0, tw_valid}, 1);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_first_word", {16'd0, tw_out}, 32'h4000);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_last_flag", {31'd0, tw_last}, 1);
        @(posedge clk); #1;
        chk("t1_busy_fall", {31'd0, busy}, 0);
        chk("t1_valid_fall", {31'd0, tw_valid}, 0);

        // T2: stages 1 and 0
        push4(16'h4000, 16'h00C0, 16'h4000, 16'h00C0);
        start_stream(3'd1, 1'b0);
        wait_idle("t2_s1");
        push4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        start_stream(3'd0, 1'b0);
        wait_idle("t2_s0");

        // T3: inverse conjugates imag, zero stays +0
        push4(16'h4000, 16'h2D2D, 16'h0040, 16'hAD2D);
        start_stream(3'd2, 1'b1);
        wait_idle("t3");

        // T4: backpressure pattern
        h0 = hs;
        push4(16'h4000, 16'h2DAD, 16'h00C0, 16'hADAD);
        tw_ready = pat[0];
        start_stream(3'd2, 1'b0);
        for (int i = 1; i < 7; i++) begin
            @(posedge clk); #1;
            tw_ready = pat[i];
        end
        wait_idle("t4");
        tw_ready = 1;
        chk("t4_handshakes", hs - h0, 4);

        // T5: start held high through RUN and the last handshake
        h0 = hs;
        push4(16'h4000, 16'h2DAD, 16'h00C0, 16'hADAD);
        @(posedge clk); #1;
        start = 1; stage = 3'd2; inverse = 0;
        @(posedge clk); #1;
        stage = 3'd1; inverse = 1;
        repeat (4) @(posedge clk);
        #1;
        start = 0;
        chk("t5_idle_after_last", {31'd0, busy}, 0);
        chk("t5_handshakes", hs - h0, 4);
        push4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        start_stream(3'd0, 1'b0);
        chk("t5_fresh_busy", {31'd0, busy}, 1);
        wait_idle("t5_fresh");

        // T6: illegal stage, then reset mid-stream
        @(posedge clk); #1;
        start = 1; stage = 3'd3;
        @(posedge clk); #1;
        start = 0;
        chk("t6_err_pulse", {31'd0, err}, 1);
        chk("t6_err_busy", {31'd0, busy}, 0);
        chk("t6_err_valid", {31'd0, tw_valid}, 0);
        @(posedge clk); #1;
        chk("t6_err_clear", {31'd0, err}, 0);

        exp_q.push_back({1'b0, 16'h4000});
        exp_q.push_back({1'b0, 16'h2DAD});
        start_stream(3'd2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_valid", {31'd0, tw_valid}, 0);
        chk("t6_rst_last", {31'd0, tw_last}, 0);
        chk("t6_rst_out", {16'd0, tw_out}, 0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_resume", {31'd0, busy}, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
